pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Converts single-cycle event pulses, such as the one-cycle strobes from the positive edge detector, back into fixed-width level windows. The windows can drive LEDs, enables, or slower downstream logic. Pulses that arrive while a window is in progress are counted and replayed in order, with a guaranteed low gap between windows. The block sits downstream of the debounce/edge-detect chain, in the shared clock domain.

## Interface
- WIDTH, 4: cycles `level_out` stays high per window; must be ≥1.
- GAP, 2: low cycles forced after every window; must be ≥1.
- PEND_W, 3: width of the pending counter, which saturates at 2^PEND_W−1.

- clk, input, 1: system clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-high; overrides all other inputs.
- pulse_in, input, 1: event strobe; each sampled-high cycle counts as one event.
- level_out, output, 1: stretched output window; registered.
- busy, output, 1: high while state ≠ IDLE; registered.
- pending, output, PEND_W: events queued but not yet started; registered.
- overflow, output, 1: sticky; set when an event is dropped, cleared only by reset.

## Operation
- States:
  - IDLE: `level_out`=0.
  - HIGH: `level_out`=1, window counter runs.
  - GAP: `level_out`=0, gap counter runs.
- IDLE: `pulse_in`=1 moves to HIGH and loads the window counter. `pending` is unchanged.
- HIGH: stays for exactly WIDTH cycles, then moves to GAP.
- GAP: stays for exactly GAP cycles. At exit:
  - If `pending`≠0, go to HIGH and decrement `pending`.
  - Else if `pulse_in`=1, go to HIGH and consume the pulse directly.
  - Else go to IDLE.
- Any `pulse_in` in HIGH or GAP that is not consumed at GAP exit increments `pending`.
- Simultaneous increment and decrement at GAP exit: `pending` is unchanged, and there is no overflow even when `pending` is saturated.
- `pending` at max with an increment and no simultaneous decrement:
  - the event is dropped;
  - `pending` stays at max;
  - `overflow` is set to 1.
- Counters are sized to clog2 of max(WIDTH, GAP). They never wrap: each is reloaded on state entry.
- `pulse_in` held high for N cycles counts as N events. The input is expected to be one-cycle strobes.
- `reset`=1 at an edge has these effects:
  - state→IDLE;
  - `level_out`, `busy`, `pending` and `overflow` all go to 0;
  - counters are cleared;
  - `pulse_in` at that edge is ignored.
- Reset in the middle of a window truncates it immediately.

## Timing
- Reset values: `level_out`=0, `busy`=0, `pending`=0, `overflow`=0.
- An event sampled at edge e in IDLE gives:
  - `level_out`=1 after edges e through e+WIDTH−1, then 0 after edge e+WIDTH;
  - GAP after edges e+WIDTH through e+WIDTH+GAP−1;
  - a decision at edge e+WIDTH+GAP.
- Latency from a sampled pulse to `level_out` high is one edge: the output is registered and there is no combinational path from `pulse_in`.
- Back-to-back windows start every WIDTH+GAP edges.
- `busy`=1 after edge e. It returns to 0 after edge e+WIDTH+GAP when nothing is queued.
- `pending` and `overflow` update on the same edge as the sampled pulse.

## Test plan
All scenarios use WIDTH=4, GAP=2, PEND_W=2 (maximum `pending` of 3) unless noted.

- **Reset:** hold `reset` for 3 cycles with `pulse_in` toggling → all outputs 0 throughout and after release; no window starts.
- **Single pulse:** `pulse_in` high at edge 10 only →
  - `level_out`=1 after edges 10–13 and 0 after edge 14;
  - `busy`=1 after edges 10–15 and 0 after edge 16;
  - `pending` stays 0.
- **Queued pulses:** pulses at edges 10, 12 and 13 →
  - windows start at edges 10, 16 and 22;
  - `pending` is 1 after edge 12, 2 after 13, 1 after 16 and 0 after 22;
  - `busy` falls after edge 28.
- **Overflow:** `pulse_in` high at edges 10–14 →
  - `pending` reaches 3 after edge 13;
  - the edge-14 event is dropped and `overflow`=1 after edge 14;
  - windows start at edges 10, 16, 22 and 28;
  - `overflow` stays 1 until reset.
- **Saturated decision edge:** `pending`=3 and a pulse at a GAP-exit edge → a new window starts, `pending` stays 3, `overflow` stays 0.
- **Mid-window reset:** pulses at edges 10 and 11, `reset` at edge 12 → after edge 12 `level_out`, `busy` and `pending` are 0; no further windows start.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed-width level windows.
// Strobes arriving during a window are queued and replayed in order, each window followed by a forced low gap.
module pulse_stretcher #(
  parameter int WIDTH  = 4,
  parameter int GAP    = 2,
  parameter int PEND_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  output logic              level_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int MAX_CNT = (WIDTH > GAP) ? WIDTH : GAP;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0]  WIN_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(GAP - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              overflow_q, overflow_d;
  logic              level_q, level_d;
  logic              busy_q, busy_d;
  logic              inc, dec;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    inc        = 1'b0;
    dec        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pulse_in) begin
          state_d = ST_HIGH;
          cnt_d   = WIN_LOAD;
        end
      end
      ST_HIGH: begin
        inc = pulse_in;
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          // Queued events win over a fresh strobe; a strobe alongside a replay is queued instead.
          if (pending_q != '0) begin
            state_d = ST_HIGH;
            cnt_d   = WIN_LOAD;
            dec     = 1'b1;
            inc     = pulse_in;
          end else if (pulse_in) begin
            state_d = ST_HIGH;
            cnt_d   = WIN_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          inc   = pulse_in;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (inc && !dec) begin
      if (pending_q == PEND_MAX) overflow_d = 1'b1;
      else                       pending_d  = pending_q + 1'b1;
    end else if (dec && !inc) begin
      pending_d = pending_q - 1'b1;
    end

    level_d = (state_d == ST_HIGH);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      level_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      level_q    <= level_d;
      busy_q     <= busy_d;
    end
  end

  assign level_out = level_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scenario bench for pulse_stretcher (WIDTH=4, GAP=2, PEND_W=2).
// Each edge's expected outputs are queued with its stimulus and compared after the edge.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulse_in = 1'b0;
  logic       level_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  typedef struct packed {
    logic       level;
    logic       busy;
    logic [1:0] pending;
    logic       ovf;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pulse_stretcher #(
    .WIDTH(4),
    .GAP(2),
    .PEND_W(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pulse_in(pulse_in),
    .level_out(level_out),
    .busy(busy),
    .pending(pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic in_window(int t, int starts[$]);
    foreach (starts[i]) if (t >= starts[i] && t <= starts[i] + 3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{level: level_out, busy: busy, pending: pending, ovf: overflow};
    return o;
  endfunction

  // Drive one edge's inputs, queue what must be seen after it, advance past the edge.
  task automatic drive(input logic p, input logic r, input obs_t e);
    pulse_in = p;
    reset    = r;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e, got;
    for (int t = 0; t < 6; t++) begin
      drive((t < 3) ? t[0] : 1'b0, (t < 3), '0);
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset t=%0d got %b exp %b", t, got, e);
      end
    end
  endtask

  task automatic test_single();
    obs_t e, got;
    int starts[$];
    starts = '{10};
    drive(1'b0, 1'b1, '0);
    void'(exp_q.pop_front());
    for (int t = 0; t <= 20; t++) begin
      e = '{level: in_window(t, starts), busy: (t >= 10 && t <= 15), pending: 2'd0, ovf: 1'b0};
      drive(t == 10, 1'b0, e);
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL single t=%0d got %b exp %b", t, got, e);
      end
    end
  endtask

  task automatic test_queued();
    obs_t e, got;
    int starts[$];
    logic [1:0] p;
    starts = '{10, 16, 22};
    drive(1'b0, 1'b1, '0);
    void'(exp_q.pop_front());
    for (int t = 0; t <= 32; t++) begin
      if (t == 12)                p = 2'd1;
      else if (t >= 13 && t < 16) p = 2'd2;
      else if (t >= 16 && t < 22) p = 2'd1;
      else                        p = 2'd0;
      e = '{level: in_window(t, starts), busy: (t >= 10 && t <= 27), pending: p, ovf: 1'b0};
      drive(t == 10 || t == 12 || t == 13, 1'b0, e);
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL queued t=%0d got %b exp %b", t, got, e);
      end
    end
  endtask

  task automatic test_overflow();
    obs_t e, got;
    int starts[$];
    logic [1:0] p;
    starts = '{10, 16, 22, 28};
    drive(1'b0, 1'b1, '0);
    void'(exp_q.pop_front());
    for (int t = 0; t <= 40; t++) begin
      if (t == 11)                p = 2'd1;
      else if (t == 12)           p = 2'd2;
      else if (t >= 13 && t < 16) p = 2'd3;
      else if (t >= 16 && t < 22) p = 2'd2;
      else if (t >= 22 && t < 28) p = 2'd1;
      else                        p = 2'd0;
      e = '{level: in_window(t, starts), busy: (t >= 10 && t <= 33), pending: p, ovf: (t >= 14)};
      drive(t >= 10 && t <= 14, 1'b0, e);
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL overflow t=%0d got %b exp %b", t, got, e);
      end
    end
  endtask

  // pending saturated at 3 while a fresh strobe lands on the edge-16 replay decision
  task automatic test_saturated_decision();
    obs_t e, got;
    int starts[$];
    logic [1:0] p;
    starts = '{10, 16, 22, 28, 34};
    drive(1'b0, 1'b1, '0);
    got = sample();
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL ovf_clear got %b exp %b", got, e);
    end
    for (int t = 0; t <= 44; t++) begin
      if (t == 11)                p = 2'd1;
      else if (t == 12)           p = 2'd2;
      else if (t >= 13 && t < 22) p = 2'd3;
      else if (t >= 22 && t < 28) p = 2'd2;
      else if (t >= 28 && t < 34) p = 2'd1;
      else                        p = 2'd0;
      e = '{level: in_window(t, starts), busy: (t >= 10 && t <= 39), pending: p, ovf: 1'b0};
      drive((t >= 10 && t <= 13) || t == 16, 1'b0, e);
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL sat_decision t=%0d got %b exp %b", t, got, e);
      end
    end
  endtask

  task automatic test_mid_window_reset();
    obs_t e, got;
    drive(1'b0, 1'b1, '0);
    void'(exp_q.pop_front());
    for (int t = 0; t <= 24; t++) begin
      e = '{level: (t == 10 || t == 11), busy: (t == 10 || t == 11),
            pending: (t == 11) ? 2'd1 : 2'd0, ovf: 1'b0};
      drive(t == 10 || t == 11, t == 12, e);
      e = exp_q.pop_front();
      got = sample();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mid_reset t=%0d got %b exp %b", t, got, e);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_queued();
    test_overflow();
    test_saturated_decision();
    test_mid_window_reset();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
